fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited request issue, in-order response capture into
// a small {pc, instr} buffer, and redirect handling that drains stale in-flight responses.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {FETCH, FLUSH} state_t;

  state_t        state, state_next;
  logic [31:0]   fetch_pc, fetch_pc_next;
  logic [CW-1:0] outstanding, outstanding_next;
  logic [CW-1:0] drop_cnt, drop_cnt_next;
  logic [CW-1:0] fifo_cnt, fifo_cnt_next;
  logic [PW-1:0] rd_ptr, rd_ptr_next, wr_ptr, wr_ptr_next;
  logic [PW-1:0] tag_rd, tag_rd_next, tag_wr, tag_wr_next;

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   tag_mem   [DEPTH];

  logic          grant, pop, push, tag_push;
  logic [CW:0]   in_use;
  logic          unused_pc_lo;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Every buffer slot is either filled or already promised to an in-flight request.
  assign in_use      = {1'b0, fifo_cnt} + {1'b0, outstanding};
  assign imem_req    = (state == FETCH) && !rst && (in_use < (CW+1)'(DEPTH));
  assign imem_addr   = fetch_pc;
  assign grant       = imem_req && imem_gnt;

  assign instr_valid = (fifo_cnt != '0);
  assign instr       = instr_mem[rd_ptr];
  assign instr_pc    = pc_mem[rd_ptr];
  assign pop         = instr_valid && instr_ready;

  assign push        = (state == FETCH) && !redirect_valid && imem_rvalid;
  assign tag_push    = grant && !redirect_valid;

  assign unused_pc_lo = ^redirect_pc[1:0];

  // NOTE: every next-value gets its hold value first, so no path leaves a signal
  // unassigned and no latch is inferred.
  always_comb begin
    state_next       = state;
    fetch_pc_next    = fetch_pc;
    outstanding_next = outstanding;
    drop_cnt_next    = drop_cnt;
    fifo_cnt_next    = fifo_cnt;
    rd_ptr_next      = rd_ptr;
    wr_ptr_next      = wr_ptr;
    tag_rd_next      = tag_rd;
    tag_wr_next      = tag_wr;

    case (state)
      FETCH: begin
        if (redirect_valid) begin
          // The pop (if any) still completes; everything behind it is stale.
          fetch_pc_next    = {redirect_pc[31:2], 2'b00};
          fifo_cnt_next    = '0;
          rd_ptr_next      = '0;
          wr_ptr_next      = '0;
          tag_rd_next      = '0;
          tag_wr_next      = '0;
          outstanding_next = '0;
          drop_cnt_next    = outstanding + CW'(grant) - CW'(imem_rvalid);
          if (drop_cnt_next != '0) state_next = FLUSH;
        end else begin
          if (grant) begin
            fetch_pc_next = fetch_pc + 32'd4;
            tag_wr_next   = ptr_inc(tag_wr);
          end
          if (push) begin
            tag_rd_next = ptr_inc(tag_rd);
            wr_ptr_next = ptr_inc(wr_ptr);
          end
          if (pop) rd_ptr_next = ptr_inc(rd_ptr);
          outstanding_next = outstanding + CW'(grant) - CW'(push);
          fifo_cnt_next    = fifo_cnt + CW'(push) - CW'(pop);
        end
      end

      FLUSH: begin
        if (redirect_valid) fetch_pc_next = {redirect_pc[31:2], 2'b00};
        if (imem_rvalid && (drop_cnt != '0)) drop_cnt_next = drop_cnt - CW'(1);
        if (drop_cnt_next == '0) state_next = FETCH;
      end

      default: state_next = FETCH;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // values of the same clock edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_cnt    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
    end else begin
      state       <= state_next;
      fetch_pc    <= fetch_pc_next;
      outstanding <= outstanding_next;
      drop_cnt    <= drop_cnt_next;
      fifo_cnt    <= fifo_cnt_next;
      rd_ptr      <= rd_ptr_next;
      wr_ptr      <= wr_ptr_next;
      tag_rd      <= tag_rd_next;
      tag_wr      <= tag_wr_next;
    end
  end

  // NOTE: storage arrays are not reset; the counts and pointers define which
  // entries are meaningful, so their contents after reset are don't-care.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= tag_mem[tag_rd];
      instr_mem[wr_ptr] <= imem_rdata;
    end
    if (tag_push) tag_mem[tag_wr] <= fetch_pc;
  end

endmodule
